bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//   Time-multiplexed driver for an N-digit 7-segment display.
//   Accepts a packed multi-digit BCD word over a valid/ready handshake and double-buffers it.
//   Presents one digit at a time, at a fixed refresh rate, to the downstream BCD-to-7-segment decoder,
//   along with a one-hot digit select.
//   Sits directly upstream of the decoder; the decoder's segment outputs are gated by digit_sel externally.
// PARAMETERS
//   NUM_DIGITS   4     digits scanned; range 2..8
//   REFRESH_DIV  1000  clk cycles each digit is shown; range >= 2
//   BLANK_LZ     1     1 = leading-zero blanking supported (gated at runtime by blank_en); 0 = never blank
// PORTS
//   clk          in   1             system clock, rising edge
//   rst_n        in   1             asynchronous active-low reset
//   load_valid   in   1             load_bcd is valid this cycle
//   load_ready   out  1             block can accept a load this cycle
//   load_bcd     in   4*NUM_DIGITS  packed BCD; nibble 0 [3:0] = least-significant digit
//   blank_en     in   1             enable leading-zero blanking (ignored if BLANK_LZ=0)
//   digit_bcd    out  4             BCD of the digit currently selected (to decoder)
//   digit_sel    out  NUM_DIGITS    one-hot, active-high digit enable
//   digit_blank  out  1             current digit is blanked; downstream forces segments off
//   bcd_err      out  1             some nibble of the active word is > 9
//   frame_done   out  1             1-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0
// BEHAVIOUR
//   Reset (async assert, sync release), all outputs registered except load_ready:
//     active=0; pending empty; idx=0; prescaler=0.
//     digit_sel=1 (digit 0), digit_bcd=0, digit_blank=0, bcd_err=0, frame_done=0, load_ready=1.
//   Prescaler:
//     Counts 0..REFRESH_DIV-1 and wraps.
//     At the terminal count, idx advances by 1; NUM_DIGITS-1 wraps to 0.
//   Outputs:
//     digit_sel, digit_bcd and digit_blank reflect the new idx one cycle after the terminal-count cycle.
//     Each digit is therefore held for exactly REFRESH_DIV cycles.
//   frame_done: asserted in the same cycle digit_sel changes to digit 0, for exactly 1 cycle.
//   Handshake:
//     load_ready = !pending_full (combinational).
//     A transfer occurs when load_valid && load_ready; load_bcd is captured into pending, and pending_full is set.
//     load_bcd is don't-care when no transfer occurs.
//   Buffer swap:
//     Happens on the terminal-count cycle of digit NUM_DIGITS-1 (the frame boundary), if pending_full is 1.
//     active <= pending and pending_full <= 0. A frame is never torn.
//   Accept and swap in the same cycle:
//     Only possible when pending was empty, so the swap does not happen.
//     New data lands in pending and is shown from the next frame boundary.
//   Multiple loads within a frame:
//     The second load is stalled (load_ready=0) until the boundary.
//   Blanking (BLANK_LZ=1 and blank_en=1):
//     Digit i is blanked iff active nibbles NUM_DIGITS-1 down to i are all zero.
//     Digit 0 is never blanked, so "0000" shows "0".
//     Blanked digit: digit_bcd=4'hF, digit_blank=1.
//     blank_en is sampled when the digit outputs update.
//   Invalid nibbles (>9):
//     Passed through unchanged on digit_bcd.
//     bcd_err=1 from the cycle after the swap, for as long as that word is active.
//   Reset mid-frame: buffer contents are discarded and the scan restarts at digit 0 with prescaler 0.
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=4)
//   Reset, no loads -> digit_sel cycles 1,2,4,8 (4 cycles each), digit_bcd=0; frame_done pulses every 16 cycles.
//   Load 16'h1234 -> after the next frame boundary: digit 0 shows 4, digit 1 shows 3, digit 2 shows 2, digit 3 shows 1; bcd_err=0.
//   Load 16'h0042 with blank_en=1 -> digits 3 and 2 show digit_bcd=F, digit_blank=1; digits 1 and 0 show 4 and 2.
//     Same load with blank_en=0 -> 0,0,4,2 with no blanking.
//   Back-to-back loads 16'h1111 then 16'h2222 in one frame -> load_ready=0 after the first load.
//     The second load is accepted the cycle after the swap, and 1111 is shown for one full frame.
//   Load 16'h00A5 -> bcd_err=1 after the swap; digit 1 shows digit_bcd=A.
//     A later load of 16'h0005 clears bcd_err at the next swap.
//   Assert rst_n=0 while digit 2 is shown with a word pending -> digit_sel=1, digit_bcd=0, load_ready=1 immediately; pending is lost.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - time-multiplexed N-digit BCD scanner with double-buffered load
// Digit outputs are registered from the post-swap word so a new word appears on the first digit of its frame.
module bcd_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic                    blank_en,
  output logic [3:0]              digit_bcd,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    digit_blank,
  output logic                    bcd_err,
  output logic                    frame_done
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_CNT = PW'(REFRESH_DIV - 1);

  logic [W-1:0]          active_q, active_d;
  logic [W-1:0]          pending_q, pending_d;
  logic                  pending_full_q, pending_full_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic [3:0]            digit_bcd_q, digit_bcd_d;
  logic                  digit_blank_q, digit_blank_d;
  logic                  bcd_err_q, bcd_err_d;
  logic                  frame_done_q, frame_done_d;

  logic       tc;
  logic       frame_end;
  logic       load_fire;
  logic       swap;
  logic       blank_now;
  logic [3:0] nib;

  // Digit k is blank when every nibble from the top down to k is zero; digit 0 never blanks.
  function automatic logic lz_blank(input logic [W-1:0] w, input logic [IW-1:0] k);
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero && (w[4*i +: 4] == 4'd0);
      if (k == IW'(i)) lz_blank = all_zero;
    end
  endfunction

  function automatic logic nibble_err(input logic [W-1:0] w);
    nibble_err = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) nibble_err = 1'b1;
    end
  endfunction

  always_comb begin
    tc        = (presc_q == LAST_CNT);
    frame_end = tc && (idx_q == LAST_IDX);
    load_fire = load_valid && !pending_full_q;
    swap      = frame_end && pending_full_q;

    presc_d = tc ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tc) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);

    active_d       = swap ? pending_q : active_q;
    pending_d      = load_fire ? load_bcd : pending_q;
    pending_full_d = pending_full_q;
    if (load_fire)  pending_full_d = 1'b1;
    else if (swap)  pending_full_d = 1'b0;

    nib = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) nib = active_d[4*i +: 4];
    end
    blank_now = BLANK_LZ && blank_en && lz_blank(active_d, idx_d);

    digit_sel_d   = digit_sel_q;
    digit_bcd_d   = digit_bcd_q;
    digit_blank_d = digit_blank_q;
    if (tc) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_sel_d[i] = (idx_d == IW'(i));
      end
      digit_bcd_d   = blank_now ? 4'hF : nib;
      digit_blank_d = blank_now;
    end

    frame_done_d = frame_end;
    bcd_err_d    = nibble_err(active_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      idx_q          <= '0;
      presc_q        <= '0;
      digit_sel_q    <= NUM_DIGITS'(1);
      digit_bcd_q    <= 4'd0;
      digit_blank_q  <= 1'b0;
      bcd_err_q      <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      idx_q          <= idx_d;
      presc_q        <= presc_d;
      digit_sel_q    <= digit_sel_d;
      digit_bcd_q    <= digit_bcd_d;
      digit_blank_q  <= digit_blank_d;
      bcd_err_q      <= bcd_err_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign load_ready  = !pending_full_q;
  assign digit_sel   = digit_sel_q;
  assign digit_bcd   = digit_bcd_q;
  assign digit_blank = digit_blank_q;
  assign bcd_err     = bcd_err_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - table-driven scoreboard bench for bcd_display_scanner (4 digits, divide by 4)
module tb_bcd_display_scanner;

  typedef struct {
    logic [15:0] word;
    logic        blank_en;
    logic [15:0] disp;
    logic [3:0]  blank;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_bcd = 16'h0;
  logic        blank_en = 1'b0;
  logic [3:0]  digit_bcd;
  logic [3:0]  digit_sel;
  logic        digit_blank;
  logic        bcd_err;
  logic        frame_done;

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];
  vec_t vecs[11];

  bcd_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_bcd(load_bcd), .blank_en(blank_en), .digit_bcd(digit_bcd), .digit_sel(digit_sel),
    .digit_blank(digit_blank), .bcd_err(bcd_err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [15:0] w, input logic b, input logic [15:0] d,
                              input logic [3:0] bl, input logic e);
    vec_t v;
    v.word = w; v.blank_en = b; v.disp = d; v.blank = bl; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input vec_t v);
    check("load_ready_at_load", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_bcd   = v.word;
    blank_en   = v.blank_en;
    exp_q.push_back(v);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_frame_done(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < bound);
    check("frame_done_timeout", 32'(frame_done), 32'd1);
  endtask

  // Starts on the first cycle of a frame and leaves on the first cycle of the next.
  task automatic check_frame();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected a pending frame");
      return;
    end
    e = exp_q.pop_front();
    for (int c = 0; c < 16; c++) begin
      int d;
      d = c / 4;
      check($sformatf("sel w=%h c=%0d", e.word, c), 32'(digit_sel), 32'(1) << d);
      check($sformatf("bcd w=%h c=%0d", e.word, c), 32'(digit_bcd), 32'(e.disp[4*d +: 4]));
      check($sformatf("blank w=%h c=%0d", e.word, c), 32'(digit_blank), 32'(e.blank[d]));
      check($sformatf("err w=%h c=%0d", e.word, c), 32'(bcd_err), 32'(e.err));
      check($sformatf("frame_done w=%h c=%0d", e.word, c), 32'(frame_done), (c == 0) ? 32'd1 : 32'd0);
      if (c != 0) load_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    vecs[0]  = mk(16'h1234, 1'b0, 16'h1234, 4'b0000, 1'b0);
    vecs[1]  = mk(16'h1234, 1'b1, 16'h1234, 4'b0000, 1'b0);
    vecs[2]  = mk(16'h0042, 1'b1, 16'hFF42, 4'b1100, 1'b0);
    vecs[3]  = mk(16'h0042, 1'b0, 16'h0042, 4'b0000, 1'b0);
    vecs[4]  = mk(16'h00A5, 1'b0, 16'h00A5, 4'b0000, 1'b1);
    vecs[5]  = mk(16'h0005, 1'b0, 16'h0005, 4'b0000, 1'b0);
    vecs[6]  = mk(16'h0000, 1'b1, 16'hFFF0, 4'b1110, 1'b0);
    vecs[7]  = mk(16'h0700, 1'b1, 16'hF700, 4'b1000, 1'b0);
    vecs[8]  = mk(16'h9999, 1'b1, 16'h9999, 4'b0000, 1'b0);
    vecs[9]  = mk(16'hF000, 1'b1, 16'hF000, 4'b0000, 1'b1);
    vecs[10] = mk(16'h00A5, 1'b1, 16'hFFA5, 4'b1100, 1'b1);

    repeat (3) @(negedge clk);
    check("rst_sel", 32'(digit_sel), 32'h1);
    check("rst_bcd", 32'(digit_bcd), 32'h0);
    check("rst_blank", 32'(digit_blank), 32'h0);
    check("rst_err", 32'(bcd_err), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_load_ready", 32'(load_ready), 32'h1);
    rst_n = 1'b1;

    wait_frame_done(40, n);
    check("first_frame_len", 32'(n), 32'd16);
    exp_q.push_back(mk(16'h0000, 1'b0, 16'h0000, 4'b0000, 1'b0));
    check_frame();

    for (int i = 0; i < 11; i++) begin
      do_load(vecs[i]);
      wait_frame_done(40, n);
      check($sformatf("load_to_frame %0d", i), 32'(n), 32'd15);
      check_frame();
    end

    // Load on the frame-boundary cycle with pending empty: no swap until the following boundary.
    repeat (15) @(negedge clk);
    load_valid = 1'b1;
    load_bcd   = 16'h4321;
    exp_q.push_back(vecs[10]);
    exp_q.push_back(mk(16'h4321, 1'b1, 16'h4321, 4'b0000, 1'b0));
    @(negedge clk);
    load_valid = 1'b0;
    check("boundary_load_ready", 32'(load_ready), 32'd0);
    check_frame();
    check_frame();

    // Back-to-back loads: the second stalls until the cycle after the swap.
    do_load(mk(16'h1111, 1'b1, 16'h1111, 4'b0000, 1'b0));
    check("b2b_ready_low", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_bcd   = 16'h2222;
    exp_q.push_back(mk(16'h2222, 1'b1, 16'h2222, 4'b0000, 1'b0));
    n = 0;
    while (!load_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ready_wait", 32'(n), 32'd15);
    check("b2b_ready_at_frame", 32'(frame_done), 32'd1);
    check_frame();
    check_frame();

    // Reset while digit 2 is shown with a word pending.
    blank_en = 1'b0;
    do_load(mk(16'h5678, 1'b0, 16'h5678, 4'b0000, 1'b0));
    void'(exp_q.pop_back());
    repeat (7) @(negedge clk);
    check("pre_rst_sel", 32'(digit_sel), 32'h4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sel", 32'(digit_sel), 32'h1);
    check("mid_rst_bcd", 32'(digit_bcd), 32'h0);
    check("mid_rst_load_ready", 32'(load_ready), 32'h1);
    check("mid_rst_frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frame_done(40, n);
    check("post_rst_frame_len", 32'(n), 32'd16);
    exp_q.push_back(mk(16'h0000, 1'b0, 16'h0000, 4'b0000, 1'b0));
    check_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
